sd_sector_reader: RTL

//  Sequencer sitting on the bus side of the byte-wide SPI master. It issues CMD17 (READ_SINGLE_BLOCK)
//  to an initialised SD card, waits for R1 and the data token, then streams 512 data bytes out with a
//  per-byte strobe. It is the only driver of the SPI master's bus port while busy; the CPU owns it otherwise.

---
 rtl/sd_sector_reader.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sd_sector_reader.sv
// Reads one 512-byte SD sector with CMD17 through the byte-wide SPI master.
// Each data byte is presented with a one-cycle strobe and its index within the sector.
module sd_sector_reader #(
    parameter int unsigned XFER_CYCLES   = 18,
    parameter int unsigned R1_TIMEOUT    = 16,
    parameter int unsigned TOKEN_TIMEOUT = 4096,
    parameter bit          SDHC          = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] lba,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic        data_valid,
    output logic [7:0]  data_out,
    output logic [8:0]  byte_index,
    output logic        spi_enable,
    output logic        spi_rnw,
    output logic [2:0]  spi_addr,
    output logic [7:0]  spi_din,
    input  logic [7:0]  spi_dout,
    input  logic        spi_ready
);
    typedef enum logic [3:0] {
        StIdle, StCsLo, StCmd, StR1, StToken, StData, StCrc, StCsHi, StTail, StFin
    } state_t;

    localparam logic [7:0]  XferLoad  = 8'(XFER_CYCLES);
    localparam logic [12:0] R1Last    = 13'(R1_TIMEOUT - 1);
    localparam logic [12:0] TokenLast = 13'(TOKEN_TIMEOUT - 1);
    localparam logic [2:0]  AddrSend  = 3'd0;
    localparam logic [2:0]  AddrPoll  = 3'd1;
    localparam logic [2:0]  AddrCsHi  = 3'd3;
    localparam logic [2:0]  AddrCsLo  = 3'd4;

    state_t      state_q;
    logic        waiting_q;
    logic [7:0]  wait_cnt_q;
    logic [12:0] poll_cnt_q;
    logic [8:0]  byte_cnt_q;
    logic [31:0] card_addr_q;
    logic [7:0]  cmd_byte;

    always_comb begin
        cmd_byte = 8'hFF;
        case (byte_cnt_q)
            9'd0:    cmd_byte = 8'h51;
            9'd1:    cmd_byte = card_addr_q[31:24];
            9'd2:    cmd_byte = card_addr_q[23:16];
            9'd3:    cmd_byte = card_addr_q[15:8];
            9'd4:    cmd_byte = card_addr_q[7:0];
            default: cmd_byte = 8'hFF;
        endcase
    end

    assign spi_rnw = 1'b0;

    // Each state issues one SPI op, waits out the transfer, then acts on the sampled byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            waiting_q   <= 1'b0;
            wait_cnt_q  <= 8'd0;
            poll_cnt_q  <= 13'd0;
            byte_cnt_q  <= 9'd0;
            card_addr_q <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
            data_valid  <= 1'b0;
            data_out    <= 8'd0;
            byte_index  <= 9'd0;
            spi_enable  <= 1'b0;
            spi_addr    <= 3'd0;
            spi_din     <= 8'd0;
        end else begin
            spi_enable <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            data_valid <= 1'b0;
            if (waiting_q) begin
                if (wait_cnt_q != 8'd0) begin
                    wait_cnt_q <= wait_cnt_q - 8'd1;
                end else begin
                    waiting_q <= 1'b0;
                    case (state_q)
                        StCsLo: begin
                            state_q    <= StCmd;
                            byte_cnt_q <= 9'd0;
                        end
                        StCmd: begin
                            if (byte_cnt_q == 9'd5) begin
                                state_q    <= StR1;
                                poll_cnt_q <= 13'd0;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 9'd1;
                            end
                        end
                        StR1: begin
                            if (spi_dout == 8'hFF) begin
                                if (poll_cnt_q == R1Last) begin
                                    err_code <= 2'd2;
                                    state_q  <= StCsHi;
                                end else begin
                                    poll_cnt_q <= poll_cnt_q + 13'd1;
                                end
                            end else if (spi_dout == 8'h00) begin
                                state_q    <= StToken;
                                poll_cnt_q <= 13'd0;
                            end else begin
                                err_code <= 2'd1;
                                state_q  <= StCsHi;
                            end
                        end
                        StToken: begin
                            if (spi_dout == 8'hFF) begin
                                if (poll_cnt_q == TokenLast) begin
                                    err_code <= 2'd3;
                                    state_q  <= StCsHi;
                                end else begin
                                    poll_cnt_q <= poll_cnt_q + 13'd1;
                                end
                            end else if (spi_dout == 8'hFE) begin
                                state_q    <= StData;
                                byte_cnt_q <= 9'd0;
                            end else begin
                                err_code <= 2'd3;
                                state_q  <= StCsHi;
                            end
                        end
                        StData: begin
                            data_valid <= 1'b1;
                            data_out   <= spi_dout;
                            byte_index <= byte_cnt_q;
                            if (byte_cnt_q == 9'd511) begin
                                state_q    <= StCrc;
                                byte_cnt_q <= 9'd0;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 9'd1;
                            end
                        end
                        StCrc: begin
                            if (byte_cnt_q == 9'd1) state_q <= StCsHi;
                            else byte_cnt_q <= byte_cnt_q + 9'd1;
                        end
                        StCsHi:  state_q <= StTail;
                        StTail:  state_q <= StFin;
                        default: state_q <= StIdle;
                    endcase
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        // busy is still high on the done/error cycle, so a start there is ignored.
                        busy <= 1'b0;
                        if (start && spi_ready && !busy) begin
                            busy        <= 1'b1;
                            err_code    <= 2'd0;
                            card_addr_q <= SDHC ? lba : {lba[22:0], 9'd0};
                            state_q     <= StCsLo;
                        end
                    end
                    StCsLo, StCsHi: begin
                        spi_enable <= 1'b1;
                        spi_addr   <= (state_q == StCsLo) ? AddrCsLo : AddrCsHi;
                        waiting_q  <= 1'b1;
                        wait_cnt_q <= 8'd1;
                    end
                    StCmd: begin
                        spi_enable <= 1'b1;
                        spi_addr   <= AddrSend;
                        spi_din    <= cmd_byte;
                        waiting_q  <= 1'b1;
                        wait_cnt_q <= XferLoad;
                    end
                    StR1, StToken, StData, StCrc, StTail: begin
                        spi_enable <= 1'b1;
                        spi_addr   <= AddrPoll;
                        waiting_q  <= 1'b1;
                        wait_cnt_q <= XferLoad;
                    end
                    StFin: begin
                        done    <= (err_code == 2'd0);
                        error   <= (err_code != 2'd0);
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end
endmodule
